// File: rtl/fft_frame_bridge.sv
// fft_frame_bridge: bridges a parallel SPI frame of N_POINTS real samples to a streaming FFT core
// (valid/ready/last plus start pulse) and gathers the complex results back into a parallel frame.
// Optional ping-pong input buffering is enabled by defining FFT_BRIDGE_PINGPONG_EN.
module fft_frame_bridge #(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned IDX_W    = $clog2(N_POINTS) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_POINTS*SAMPLE_W-1:0]    frame_in,
    input  logic                            frame_in_valid,
    output logic                            frame_in_ready,
    output logic [2*SAMPLE_W-1:0]           fft_in_data,
    output logic                            fft_in_valid,
    input  logic                            fft_in_ready,
    output logic                            fft_in_last,
    output logic                            fft_start,
    input  logic [2*SAMPLE_W-1:0]           fft_out_data,
    input  logic                            fft_out_valid,
    input  logic                            fft_out_last,
    output logic [N_POINTS*2*SAMPLE_W-1:0]  frame_out,
    output logic                            frame_out_valid,
    input  logic                            frame_out_ack,
    output logic                            err_short,
    output logic                            err_overrun
);

    localparam int unsigned WordW = 2 * SAMPLE_W;
    localparam int unsigned FrameW = N_POINTS * WordW;
    localparam int unsigned AddrW = IDX_W - 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_POINTS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StCollect, StHold} state_e;

    state_e              state_q;
    logic [SAMPLE_W-1:0] buf_q [N_POINTS];
    logic [IDX_W-1:0]    idx_q;
    logic [FrameW-1:0]   frame_out_q;
    logic                fft_in_valid_q;
    logic                fft_start_q;
    logic                frame_out_valid_q;
    logic                err_short_q;
    logic                err_overrun_q;

    logic [SAMPLE_W-1:0] in_samples [N_POINTS];
    logic [FrameW-1:0]   shifted_frame;
    logic [FrameW-1:0]   collect_frame;
    logic [IDX_W-1:0]    pad_slots;
    logic                short_hit;

`ifdef FFT_BRIDGE_PINGPONG_EN
    logic [SAMPLE_W-1:0] shadow_q [N_POINTS];
    logic                shadow_full_q;
    logic                shadow_capture;
`endif

    // Split the parallel input frame into samples; sample 0 sits in the MSBs.
    always_comb begin
        for (int i = 0; i < N_POINTS; i++) begin
            in_samples[i] = frame_in[(N_POINTS-i)*SAMPLE_W-1 -: SAMPLE_W];
        end
    end

    // Next collected frame: shift the word in, zero-fill the missing tail on an early last.
    always_comb begin
        shifted_frame = {frame_out_q[FrameW-WordW-1:0], fft_out_data};
        pad_slots     = LastIdx - idx_q;
        short_hit     = fft_out_last && (idx_q < LastIdx);
        collect_frame = short_hit ? (shifted_frame << (32'(pad_slots) * WordW)) : shifted_frame;
    end

    // Input readiness; with ping-pong, any state accepts a frame while the shadow is free.
    always_comb begin
`ifdef FFT_BRIDGE_PINGPONG_EN
        frame_in_ready = !shadow_full_q;
        // A capture in HOLD alongside ack is loaded straight into the active buffer instead.
        shadow_capture = frame_in_valid && !shadow_full_q && (state_q != StIdle) &&
                         !((state_q == StHold) && frame_out_ack);
`else
        frame_in_ready = (state_q == StIdle);
`endif
    end

    // Main control: capture, stream to the FFT, collect results, hold for readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            buf_q             <= '{default: '0};
            idx_q             <= '0;
            frame_out_q       <= '0;
            fft_in_valid_q    <= 1'b0;
            fft_start_q       <= 1'b0;
            frame_out_valid_q <= 1'b0;
            err_short_q       <= 1'b0;
            err_overrun_q     <= 1'b0;
`ifdef FFT_BRIDGE_PINGPONG_EN
            shadow_q          <= '{default: '0};
            shadow_full_q     <= 1'b0;
`endif
        end else begin
            fft_start_q <= 1'b0;
            // Results are only expected while collecting; anything else is dropped and flagged.
            if (fft_out_valid && (state_q != StCollect)) begin
                err_overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (frame_in_valid) begin
                        buf_q          <= in_samples;
                        idx_q          <= '0;
                        fft_in_valid_q <= 1'b1;
                        state_q        <= StSend;
                    end
                end
                StSend: begin
                    if (fft_in_ready) begin
                        if (idx_q == LastIdx) begin
                            fft_in_valid_q <= 1'b0;
                            fft_start_q    <= 1'b1;
                            frame_out_q    <= '0;
                            idx_q          <= '0;
                            state_q        <= StCollect;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StCollect: begin
                    if (fft_out_valid) begin
                        frame_out_q <= collect_frame;
                        idx_q       <= idx_q + IDX_W'(1);
                        if (short_hit) begin
                            err_short_q <= 1'b1;
                        end
                        if (short_hit || (idx_q == LastIdx)) begin
                            frame_out_valid_q <= 1'b1;
                            state_q           <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (frame_out_ack) begin
                        frame_out_valid_q <= 1'b0;
`ifdef FFT_BRIDGE_PINGPONG_EN
                        if (shadow_full_q) begin
                            buf_q          <= shadow_q;
                            shadow_full_q  <= 1'b0;
                            idx_q          <= '0;
                            fft_in_valid_q <= 1'b1;
                            state_q        <= StSend;
                        end else if (frame_in_valid) begin
                            buf_q          <= in_samples;
                            idx_q          <= '0;
                            fft_in_valid_q <= 1'b1;
                            state_q        <= StSend;
                        end else begin
                            state_q <= StIdle;
                        end
`else
                        state_q <= StIdle;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef FFT_BRIDGE_PINGPONG_EN
            if (shadow_capture) begin
                shadow_q      <= in_samples;
                shadow_full_q <= 1'b1;
            end
`endif
        end
    end

    assign fft_in_data     = fft_in_valid_q ? {buf_q[idx_q[AddrW-1:0]], {SAMPLE_W{1'b0}}} : '0;
    assign fft_in_valid    = fft_in_valid_q;
    assign fft_in_last     = fft_in_valid_q && (idx_q == LastIdx);
    assign fft_start       = fft_start_q;
    assign frame_out       = frame_out_q;
    assign frame_out_valid = frame_out_valid_q;
    assign err_short       = err_short_q;
    assign err_overrun     = err_overrun_q;

endmodule

// File: tb/tb_fft_frame_bridge.sv
// Self-checking bench for fft_frame_bridge with N_POINTS=4, SAMPLE_W=16.
module tb_fft_frame_bridge;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] frame_in;
    logic           frame_in_valid;
    logic           frame_in_ready;
    logic [2*W-1:0] fft_in_data;
    logic           fft_in_valid;
    logic           fft_in_ready;
    logic           fft_in_last;
    logic           fft_start;
    logic [2*W-1:0] fft_out_data;
    logic           fft_out_valid;
    logic           fft_out_last;
    logic [N*2*W-1:0] frame_out;
    logic           frame_out_valid;
    logic           frame_out_ack;
    logic           err_short;
    logic           err_overrun;

    always #5 clk = ~clk;

    fft_frame_bridge #(.N_POINTS(N), .SAMPLE_W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_in       (frame_in),
        .frame_in_valid (frame_in_valid),
        .frame_in_ready (frame_in_ready),
        .fft_in_data    (fft_in_data),
        .fft_in_valid   (fft_in_valid),
        .fft_in_ready   (fft_in_ready),
        .fft_in_last    (fft_in_last),
        .fft_start      (fft_start),
        .fft_out_data   (fft_out_data),
        .fft_out_valid  (fft_out_valid),
        .fft_out_last   (fft_out_last),
        .frame_out      (frame_out),
        .frame_out_valid(frame_out_valid),
        .frame_out_ack  (frame_out_ack),
        .err_short      (err_short),
        .err_overrun    (err_overrun)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    logic err_short_m;

    typedef struct {
        logic [63:0]  frame;
        int           stall_beat;
        int           stall_len;
        logic [127:0] res;
        int           nres;
        logic [127:0] want_frame;
        logic         want_short;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Word k of the stream: sample k in the real half, zero imaginary half.
    function automatic logic [31:0] exp_word(input logic [63:0] frame, input int k);
        logic [63:0] s;
        s = (frame >> (W * (N - 1 - k))) & 64'hFFFF;
        return {s[15:0], 16'h0000};
    endfunction

    // Collected frame: the first nres result words from the MSB side, zeros after them.
    function automatic logic [127:0] exp_frame(input logic [127:0] res, input int nres);
        logic [127:0] ones;
        ones = '1;
        return res & ~(ones >> (32 * nres));
    endfunction

    task automatic run_frame(input logic [63:0] frame, input int stall_beat, input int stall_len,
                             input logic [127:0] res, input int nres,
                             input logic [127:0] want_frame, input logic want_short,
                             input bit gaps);
        int k = 0;
        int stalled = 0;
        int cyc = 0;
        @(negedge clk);
        chk("in_ready_idle", frame_in_ready, 1);
        frame_in = frame;
        frame_in_valid = 1'b1;
        while (k < N && cyc < 40) begin
            @(negedge clk);
            frame_in_valid = 1'b0;
            cyc++;
            chk("in_valid", fft_in_valid, 1);
            chk("in_data", fft_in_data, exp_word(frame, k));
            chk("in_last", fft_in_last, k == N - 1);
            chk("start_early", fft_start, 0);
`ifndef FFT_BRIDGE_PINGPONG_EN
            chk("in_ready_busy", frame_in_ready, 0);
`endif
            if (k == stall_beat && stalled < stall_len) begin
                fft_in_ready = 1'b0;
                stalled++;
            end else begin
                fft_in_ready = 1'b1;
                k++;
            end
        end
        chk("send_done", k, N);
        @(negedge clk);
        fft_in_ready = 1'b0;
        chk("start", fft_start, 1);
        chk("in_valid_after", fft_in_valid, 0);
        @(negedge clk);
        chk("start_width", fft_start, 0);
        for (int j = 0; j < nres; j++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                fft_out_valid = 1'b0;
                fft_out_last = 1'b0;
                @(negedge clk);
            end
            fft_out_valid = 1'b1;
            fft_out_data = res[127-32*j -: 32];
            fft_out_last = (j == nres - 1);
            @(negedge clk);
        end
        fft_out_valid = 1'b0;
        fft_out_last = 1'b0;
        chk("out_valid", frame_out_valid, 1);
        chk("out_frame", frame_out, want_frame);
        chk("err_short", err_short, want_short);
        chk("no_overrun", err_overrun, 0);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("hold_valid", frame_out_valid, 1);
            chk("hold_frame", frame_out, want_frame);
        end
        frame_out_ack = 1'b1;
        @(negedge clk);
        frame_out_ack = 1'b0;
        chk("out_valid_cleared", frame_out_valid, 0);
        chk("ready_after_ack", frame_in_ready, 1);
        chk("frame_kept", frame_out, want_frame);
    endtask

    initial begin
        tbl[0] = '{64'h0001_0002_0003_0004, 0, 0, 128'h0000000A_0000000B_0000000C_0000000D, 4,
                   128'h0000000A_0000000B_0000000C_0000000D, 1'b0};
        tbl[1] = '{64'h0001_0002_0003_0004, 1, 3, 128'h0000000A_0000000B_0000000C_0000000D, 4,
                   128'h0000000A_0000000B_0000000C_0000000D, 1'b0};
        tbl[2] = '{64'h0001_0002_0003_0004, 0, 0, 128'h0000000A_0000000B_0000000C_0000000D, 2,
                   128'h0000000A_0000000B_00000000_00000000, 1'b1};
        tbl[3] = '{64'hFFFF_8000_7FFF_0000, 3, 2, 128'h11111111_22222222_33333333_44444444, 4,
                   128'h11111111_22222222_33333333_44444444, 1'b1};
        tbl[4] = '{64'h1234_5678_9ABC_DEF0, 2, 1, 128'hDEADBEEF_01010101_02020202_03030303, 1,
                   128'hDEADBEEF_00000000_00000000_00000000, 1'b1};

        reset = 1'b1;
        frame_in = '0;
        frame_in_valid = 1'b0;
        fft_in_ready = 1'b0;
        fft_out_data = '0;
        fft_out_valid = 1'b0;
        fft_out_last = 1'b0;
        frame_out_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", frame_in_ready, 1);
        chk("rst_in_valid", fft_in_valid, 0);
        chk("rst_in_data", fft_in_data, 0);
        chk("rst_in_last", fft_in_last, 0);
        chk("rst_start", fft_start, 0);
        chk("rst_frame_out", frame_out, 0);
        chk("rst_out_valid", frame_out_valid, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_overrun", err_overrun, 0);

        // Directed vectors from the table.
        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].frame, tbl[v].stall_beat, tbl[v].stall_len, tbl[v].res,
                      tbl[v].nres, tbl[v].want_frame, tbl[v].want_short, 1'b0);
        end

        // Result word while idle is dropped and flagged.
        @(negedge clk);
        fft_out_valid = 1'b1;
        fft_out_data = 32'h12345678;
        fft_out_last = 1'b1;
        @(negedge clk);
        fft_out_valid = 1'b0;
        fft_out_last = 1'b0;
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_frame_kept", frame_out, tbl[4].want_frame);
        chk("overrun_out_valid", frame_out_valid, 0);
        chk("overrun_ready", frame_in_ready, 1);

        // Reset in the middle of SEND aborts without a start pulse.
        @(negedge clk);
        frame_in = 64'hCAFE_0001_0002_0003;
        frame_in_valid = 1'b1;
        @(negedge clk);
        frame_in_valid = 1'b0;
        fft_in_ready = 1'b0;
        chk("mid_send_valid", fft_in_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_valid", fft_in_valid, 0);
        chk("abort_ready", frame_in_ready, 1);
        chk("abort_err_short", err_short, 0);
        chk("abort_err_overrun", err_overrun, 0);
        fft_in_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_start", fft_start, 0);
            chk("abort_idle", fft_in_valid, 0);
        end
        fft_in_ready = 1'b0;
        err_short_m = 1'b0;

        // Randomized frames against the reference model.
        for (int r = 0; r < 12; r++) begin
            logic [63:0]  f;
            logic [127:0] res;
            int           nres;
            f = {$urandom, $urandom};
            res = {$urandom, $urandom, $urandom, $urandom};
            nres = $urandom_range(1, N);
            err_short_m = err_short_m | (nres < N);
            run_frame(f, $urandom_range(0, N - 1), $urandom_range(0, 3), res, nres,
                      exp_frame(res, nres), err_short_m, 1'b1);
        end

`ifdef FFT_BRIDGE_PINGPONG_EN
        // Second frame offered during COLLECT restarts SEND straight after the ack.
        begin
            logic [63:0] fa;
            logic [63:0] fb;
            int          cyc;
            fa = 64'hAAAA_0001_0002_0003;
            fb = 64'hBBBB_1111_2222_3333;
            cyc = 0;
            @(negedge clk);
            frame_in = fa;
            frame_in_valid = 1'b1;
            fft_in_ready = 1'b1;
            @(negedge clk);
            frame_in_valid = 1'b0;
            while (!fft_start && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("pp_start", fft_start, 1);
            fft_in_ready = 1'b0;
            chk("pp_ready_collect", frame_in_ready, 1);
            frame_in = fb;
            frame_in_valid = 1'b1;
            @(negedge clk);
            frame_in_valid = 1'b0;
            chk("pp_ready_full", frame_in_ready, 0);
            for (int j = 0; j < N; j++) begin
                fft_out_valid = 1'b1;
                fft_out_data = 32'(j + 1);
                fft_out_last = (j == N - 1);
                @(negedge clk);
            end
            fft_out_valid = 1'b0;
            fft_out_last = 1'b0;
            chk("pp_hold", frame_out_valid, 1);
            chk("pp_frame", frame_out, 128'h00000001_00000002_00000003_00000004);
            frame_out_ack = 1'b1;
            @(negedge clk);
            frame_out_ack = 1'b0;
            chk("pp_out_valid_cleared", frame_out_valid, 0);
            chk("pp_ready_free", frame_in_ready, 1);
            fft_in_ready = 1'b1;
            for (int k = 0; k < N; k++) begin
                chk("pp_resend_valid", fft_in_valid, 1);
                chk("pp_resend_data", fft_in_data, exp_word(fb, k));
                @(negedge clk);
            end
            chk("pp_start2", fft_start, 1);
            fft_in_ready = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
